// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_divider_pkg;

   // Default operand/result width in bits
   localparam int DIV_WIDTH_DEFAULT = 8;

   // Controller states: waiting, iterating one bit per cycle, result pulse
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage : seq_divider_pkg

// File: rtl/div_step.sv
// Single combinational restoring-division step: shift, compare, conditional subtract.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
import seq_divider_pkg::*;

module div_step #(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             dvd_msb_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_bit_o
);

   // The incoming partial remainder is always < divisor, so its top bit is
   // always zero and only the low WIDTH bits take part in the shift.
   logic             rem_top_unused;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   dvs_ext;

   assign rem_top_unused = rem_i[WIDTH];

   // Shift in the next dividend bit, then subtract the divisor if it fits
   always_comb begin
      shifted = {rem_i[WIDTH-1:0], dvd_msb_i};
      dvs_ext = {1'b0, divisor_i};
      q_bit_o = (shifted >= dvs_ext);
      rem_o   = q_bit_o ? (shifted - dvs_ext) : shifted;
   end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: done pulses WIDTH+1 cycles after an accepted start (1 cycle for a zero divisor with SEQ_DIVIDER_ZERO_CHK_EN).
// Backpressure: start is ignored while busy; results hold until the next done pulse.
import seq_divider_pkg::*;

module seq_divider #(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Partial remainder, one bit wider than the operands
   logic [WIDTH:0]   rem_q, rem_d;
   // Dividend bits shift out of the MSB while quotient bits shift into the
   // LSB; after WIDTH steps this register holds the full quotient.
   logic [WIDTH-1:0] dq_q, dq_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   // Architectural results, only updated on entry to DONE
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] res_rem_q, res_rem_d;

   logic             accept;
   logic             last_step;
   logic [WIDTH:0]   step_rem;
   logic             step_qbit;

   assign accept    = start && (state_q != RUN);
   assign last_step = (state_q == RUN) && (cnt_q == CNT_LAST);

`ifdef SEQ_DIVIDER_ZERO_CHK_EN
   logic div_zero;
   logic err_q, err_d;
   assign div_zero = (divisor == '0);
`endif

   div_step #(
      .WIDTH(WIDTH)
   ) u_div_step (
      .rem_i     (rem_q),
      .dvd_msb_i (dq_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_qbit)
   );

   // State register; reset aborts any division in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DONE re-enters RUN directly on start, so no bubble
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
               state_d = div_zero ? DONE : RUN;
`else
               state_d = RUN;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Datapath next-state: load on accept, iterate in RUN, publish on last step
   always_comb begin
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dq_d      = dq_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      res_rem_d = res_rem_q;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
      err_d     = err_q;
`endif
      if (accept) begin
         cnt_d = CNT_LOAD;
         rem_d = '0;
         dq_d  = dividend;
         dvs_d = divisor;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
         // Zero divisor short-circuits straight to the result
         if (div_zero) begin
            quo_d     = '1;
            res_rem_d = dividend;
            err_d     = 1'b1;
         end
`endif
      end else if (state_q == RUN) begin
         cnt_d = cnt_q - CNT_LAST;
         rem_d = step_rem;
         dq_d  = {dq_q[WIDTH-2:0], step_qbit};
         if (last_step) begin
            quo_d     = {dq_q[WIDTH-2:0], step_qbit};
            res_rem_d = step_rem[WIDTH-1:0];
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
            err_d     = 1'b0;
`endif
         end
      end
   end

   // Datapath registers; results clear on reset so outputs drop immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         dq_q      <= '0;
         dvs_q     <= '0;
         quo_q     <= '0;
         res_rem_q <= '0;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dq_q      <= dq_d;
         dvs_q     <= dvs_d;
         quo_q     <= quo_d;
         res_rem_q <= res_rem_d;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
         err_q     <= err_d;
`endif
      end
   end

   assign quotient  = quo_q;
   assign remainder = res_rem_q;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
   assign div_err   = err_q;
`else
   assign div_err   = 1'b0;
`endif

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Scoreboarded directed bench for seq_divider (WIDTH=8).
// Latency: expected done cycle is recorded per transaction and checked.
// Backpressure: exercises ignored starts in RUN and back-to-back restart from DONE.
module tb_seq_divider;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         e;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_err;
   logic [W-1:0] quotient, remainder;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   logic [W-1:0] last_q = '0;
   logic [W-1:0] last_r = '0;
   logic         last_e = 1'b0;

`ifdef SEQ_DIVIDER_ZERO_CHK_EN
   localparam int  ZLAT = 0;
   localparam logic ZERR = 1'b1;
`else
   localparam int  ZLAT = 8;
   localparam logic ZERR = 1'b0;
`endif

   seq_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_err   (div_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: pop and compare on every done; otherwise results must hold
   always @(negedge clk) begin
      if (!rst_n) begin
         last_q <= '0;
         last_r <= '0;
         last_e <= 1'b0;
      end else if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            chk("quotient", int'(quotient), int'(x.q));
            chk("remainder", int'(remainder), int'(x.r));
            chk("div_err", int'(div_err), int'(x.e));
            chk("done_cycle", cyc, x.cyc);
            last_q <= x.q;
            last_r <= x.r;
            last_e <= x.e;
         end
      end else begin
         chk("hold_quotient", int'(quotient), int'(last_q));
         chk("hold_remainder", int'(remainder), int'(last_r));
         chk("hold_div_err", int'(div_err), int'(last_e));
      end
   end

   // Drive one start for a single cycle; called and returns at a negedge
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ee, input int lat);
      exp_t x;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      x.q = eq; x.r = er; x.e = ee; x.cyc = cyc + 1 + lat;
      exp_q.push_back(x);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      // Reset state
      idle(2);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_div_err", int'(div_err), 0);
      rst_n = 1'b1;

      // 100/7 with busy profile: busy cycles 1..8, done cycle 9
      issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
      for (int k = 1; k <= 8; k++) begin
         chk("busy_run", int'(busy), 1);
         @(negedge clk);
      end
      chk("busy_done_cycle", int'(busy), 0);
      idle(2);

      issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
      idle(10);
      issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
      idle(10);
      issue(8'd200, 8'd0, 8'd255, 8'd200, ZERR, ZLAT);
      idle(10);

      // Reset at cycle 4 of a run: outputs clear at once, no done
      issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
      idle(3);
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_quotient", int'(quotient), 0);
      chk("midrst_remainder", int'(remainder), 0);
      chk("midrst_div_err", int'(div_err), 0);
      idle(3);
      rst_n = 1'b1;
      // Start on the very first edge after reset release
      issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
      idle(10);

      // Start held through the run, operands changed mid-run, restart from DONE
      begin
         exp_t x;
         int   t0;
         t0       = cyc;
         dividend = 8'd50;
         divisor  = 8'd3;
         start    = 1'b1;
         x.q = 8'd16; x.r = 8'd2; x.e = 1'b0; x.cyc = t0 + 9;
         exp_q.push_back(x);
         idle(4);
         dividend = 8'd60;
         divisor  = 8'd4;
         idle(5);
         chk("b2b_done_cycle", int'(done), 1);
         x.q = 8'd15; x.r = 8'd0; x.e = 1'b0; x.cyc = t0 + 18;
         exp_q.push_back(x);
         @(negedge clk);
         start = 1'b0;
         chk("b2b_no_bubble", int'(busy), 1);
         idle(12);
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_seq_divider
